sm83_fetch_unit: RTL
====================

Name: sm83_fetch_unit

Overview:
Instruction fetch and assembly stage that produces the byte stream consumed by the SM83 decode stage.
- Reads opcode, CB-prefix and immediate bytes from the memory bus using a req/ack handshake.
- Tracks PC and presents one complete instruction per transfer: opcode, CB flag and 16-bit immediate.
- Redirects on jumps from the control unit, discarding any in-flight fetch.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset (boot ROM entry).

Ports:
- clk  input  1  core clock.
- rst_n  input  1  reset, asynchronous, active-low.
- mem_req  output  1  read request; held high until mem_ack.
- mem_addr  output  16  read address; stable while mem_req is high.
- mem_rdata  input  8  read data; valid only in the mem_ack cycle.
- mem_ack  input  1  one-cycle read completion.
- o_valid  output  1  instruction bundle valid.
- i_ready  input  1  decode/control accepts the bundle.
- o_instr  output  8  opcode byte, or second byte for CB instructions.
- o_is_instr16  output  1  bundle is a CB-prefixed instruction.
- o_imm  output  16  immediate, little-endian assembled; zero-extended for 1-byte immediates.
- o_len  output  2  total instruction length in bytes (1..3).
- o_pc  output  16  address of the first instruction byte.
- i_redirect  input  1  load new PC; flush everything.
- i_redirect_pc  input  16  redirect target.

Behaviour:
Reset:
- State S_OP; pc = RESET_PC.
- mem_req = 0, o_valid = 0, o_instr = 0, o_is_instr16 = 0, o_imm = 0, o_len = 0, o_pc = RESET_PC.
- mem_req rises on the first clock after deassertion.

States:
- S_OP: request pc. On ack:
  - Latch the opcode and set o_pc = pc.
  - 0xCB -> S_CB.
  - Otherwise, length 1 -> S_OUT; length 2/3 -> S_IMM_LO.
- S_CB: request pc. On ack, o_instr = byte, o_is_instr16 = 1, length = 2 -> S_OUT.
- S_IMM_LO: on ack, imm[7:0] = byte. Length 2 -> S_OUT; length 3 -> S_IMM_HI.
- S_IMM_HI: on ack, imm[15:8] = byte -> S_OUT.
- S_OUT: o_valid = 1 and mem_req = 0. Bundle is held stable until i_ready. On o_valid && i_ready, clear bundle fields -> S_OP.

PC and bus:
- pc increments by 1, mod 2^16, on every accepted ack. 0xFFFF wraps to 0x0000.
- mem_addr = pc while requesting. Fetch of each byte is one req/ack transaction; mem_req may stay high back-to-back across bytes.

Instruction length (sub-module):
- 3 bytes: 0x01, 0x11, 0x21, 0x31, 0x08, 0xC2, 0xC3, 0xC4, 0xCA, 0xCC, 0xCD, 0xD2, 0xD4, 0xDA, 0xDC, 0xEA, 0xFA.
- 2 bytes:
  - 0x06/0E/16/1E/26/2E/36/3E.
  - 0x10 (STOP; second byte fetched into imm[7:0]).
  - 0x18/20/28/30/38.
  - 0xC6/CE/D6/DE/E6/EE/F6/FE.
  - 0xE0, 0xF0, 0xE8, 0xF8.
- All others, including illegal opcodes: 1 byte.

Redirect (highest priority, any state):
- Next cycle: pc = i_redirect_pc, state = S_OP, o_valid = 0, partial bundle discarded.
- A mem_ack in the same cycle as i_redirect is ignored.
- An outstanding request is abandoned: mem_req drops for exactly one cycle, then re-requests the new pc.
- i_redirect together with o_valid && i_ready: the handshake completes, then the redirect applies.

Other rules:
- mem_ack while mem_req = 0 is ignored.
- No prefetch beyond one instruction; the bus is idle in S_OUT.

Decomposition:
sm83_pkg additions:
- fetch_state_t enum (S_OP, S_CB, S_IMM_LO, S_IMM_HI, S_OUT).
- OP_INSTR_16 (0xCB), shared with decode.
- instr_len_t (2-bit).
- function instr_len(opcode8_t).

Sub-module: sm83_instr_len, a combinational opcode -> length table, instantiated once and reused by a future disassembler/trace monitor.

Test Plan:
- Reset, memory 0x0000 = 0x00 (NOP), ack one cycle after req -> o_valid with o_instr = 0x00, o_len = 1, o_pc = 0x0000, o_imm = 0; next mem_addr = 0x0001.
- Bytes C3 50 01 at 0x0100 (JP a16) -> three transactions, then o_instr = 0xC3, o_imm = 0x0150, o_len = 3, o_pc = 0x0100; held for 4 cycles while i_ready = 0.
- Bytes CB 37 (SWAP A) -> o_instr = 0x37, o_is_instr16 = 1, o_len = 2, o_imm = 0.
- Bytes 3E 7F at 0xFFFF/0x0000 (LD A,d8 across wrap) -> o_imm = 0x007F, o_pc = 0xFFFF, next fetch at 0x0001.
- i_redirect to 0x4000 in the same cycle as the ack of the imm-lo byte of 0x21 -> byte discarded, no o_valid, next request mem_addr = 0x4000.
- Assert rst_n low mid-S_IMM_HI -> mem_req = 0, o_valid = 0 immediately (asynchronous); after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/sm83_pkg.sv
// +----------------------------------------------------------------------+
// | sm83_pkg: shared SM83 types, constants and the opcode length table.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package sm83_pkg;

  typedef logic [7:0] opcode8_t;
  typedef logic [1:0] instr_len_t;

  localparam opcode8_t OP_INSTR_16 = 8'hCB;

  typedef enum logic [2:0] {
    S_OP     = 3'd0,
    S_CB     = 3'd1,
    S_IMM_LO = 3'd2,
    S_IMM_HI = 3'd3,
    S_OUT    = 3'd4
  } fetch_state_t;

  // The CB prefix itself reports 1; its two-byte length is handled by fetch.
  function automatic instr_len_t instr_len(input opcode8_t i_op);
    instr_len_t w_len;
    case (i_op)
      8'h01, 8'h11, 8'h21, 8'h31, 8'h08,
      8'hC2, 8'hC3, 8'hC4, 8'hCA, 8'hCC, 8'hCD,
      8'hD2, 8'hD4, 8'hDA, 8'hDC, 8'hEA, 8'hFA: w_len = 2'd3;
      8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
      8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
      8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
      8'hE0, 8'hF0, 8'hE8, 8'hF8:               w_len = 2'd2;
      default:                                  w_len = 2'd1;
    endcase
    return w_len;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sm83_instr_len.sv
// +----------------------------------------------------------------------+
// | sm83_instr_len: combinational opcode -> instruction length lookup.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module sm83_instr_len
  import sm83_pkg::*;
(
  input  logic [7:0] i_opcode,
  output logic [1:0] o_len
);

  assign o_len = instr_len(i_opcode);

endmodule

`default_nettype wire

// File: rtl/sm83_fetch_unit.sv
// +----------------------------------------------------------------------+
// | sm83_fetch_unit: fetches and assembles one SM83 instruction bundle.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module sm83_fetch_unit
  import sm83_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [7:0]  o_instr,
  output logic        o_is_instr16,
  output logic [15:0] o_imm,
  output logic [1:0]  o_len,
  output logic [15:0] o_pc,
  input  logic        i_redirect,
  input  logic [15:0] i_redirect_pc
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic         r_req;
  logic         w_req_nxt;
  logic [15:0]  r_pc;
  logic [15:0]  r_op_pc;
  logic [15:0]  r_imm;
  logic [7:0]   r_instr;
  logic         r_is16;
  logic [1:0]   r_len;
  logic [1:0]   w_op_len;
  logic         w_acc;
  logic         w_take;

  sm83_instr_len u_instr_len (
    .i_opcode (mem_rdata),
    .o_len    (w_op_len)
  );

  assign w_acc  = r_req & mem_ack & ~i_redirect;
  assign w_take = (r_state == S_OUT) & i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_OP;
      r_req   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = 1'b0;
    case (r_state)
      S_OP: begin
        if (w_acc) begin
          if (mem_rdata == OP_INSTR_16)  w_state_nxt = S_CB;
          else if (w_op_len == 2'd1)     w_state_nxt = S_OUT;
          else                           w_state_nxt = S_IMM_LO;
        end
      end
      S_CB:     if (w_acc) w_state_nxt = S_OUT;
      S_IMM_LO: if (w_acc) w_state_nxt = (r_len == 2'd2) ? S_OUT : S_IMM_HI;
      S_IMM_HI: if (w_acc) w_state_nxt = S_OUT;
      S_OUT:    if (i_ready) w_state_nxt = S_OP;
      default:  w_state_nxt = S_OP;
    endcase
    if (i_redirect) w_state_nxt = S_OP;
    // Redirect forces a one-cycle bus bubble before the new target is requested.
    w_req_nxt = (w_state_nxt != S_OUT) && !i_redirect;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= RESET_PC;
      r_op_pc <= RESET_PC;
      r_imm   <= 16'h0000;
      r_instr <= 8'h00;
      r_is16  <= 1'b0;
      r_len   <= 2'd0;
    end else if (i_redirect) begin
      r_pc    <= i_redirect_pc;
      r_imm   <= 16'h0000;
      r_instr <= 8'h00;
      r_is16  <= 1'b0;
      r_len   <= 2'd0;
    end else if (w_acc) begin
      r_pc <= r_pc + 16'd1;
      case (r_state)
        S_OP: begin
          r_op_pc <= r_pc;
          r_instr <= mem_rdata;
          r_is16  <= 1'b0;
          r_imm   <= 16'h0000;
          r_len   <= (mem_rdata == OP_INSTR_16) ? 2'd2 : w_op_len;
        end
        S_CB: begin
          r_instr <= mem_rdata;
          r_is16  <= 1'b1;
          r_len   <= 2'd2;
        end
        S_IMM_LO: r_imm[7:0]  <= mem_rdata;
        S_IMM_HI: r_imm[15:8] <= mem_rdata;
        default:  r_imm       <= r_imm;
      endcase
    end else if (w_take) begin
      r_imm   <= 16'h0000;
      r_instr <= 8'h00;
      r_is16  <= 1'b0;
      r_len   <= 2'd0;
    end
  end

  assign mem_req      = r_req;
  assign mem_addr     = r_pc;
  assign o_valid      = (r_state == S_OUT);
  assign o_instr      = r_instr;
  assign o_is_instr16 = r_is16;
  assign o_imm        = r_imm;
  assign o_len        = r_len;
  assign o_pc         = r_op_pc;

endmodule

`default_nettype wire
